// File: rtl/ram_burst_sequencer.sv
// Turns one granted arbiter request (line burst or single word) into per-word
// accesses on a single-port synchronous RAM, with read-valid/write-req/last strobes.
module ram_burst_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           mem_addr,
  input  logic                  mem_enable,
  input  logic                  mem_rw,
  input  logic                  mem_op_size,
  input  logic [DATA_WIDTH-1:0] mem_write,
  output logic                  mem_write_req,
  output logic [DATA_WIDTH-1:0] mem_read,
  output logic                  mem_read_valid,
  output logic                  mem_last,
  output logic                  busy,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam logic MEM_WRITE = 1'b1;
  localparam int   LB        = $clog2(BURST_LEN);
  localparam int   CW        = LB + 1;

  localparam logic [CW-1:0]         LAST_BURST = CW'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK  = ~ADDR_WIDTH'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WRITE,
    S_GAP
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         r_cnt_max;
  logic [ADDR_WIDTH-1:0] r_base;
  logic                  r_valid;
  logic                  r_rlast;

  logic [ADDR_WIDTH-1:0] w_word_addr;
  logic [ADDR_WIDTH-1:0] w_line_base;
  logic                  w_issue_rd;
  logic                  w_issue_wr;
  logic                  w_cnt_end;
  logic                  w_unused;

  assign w_word_addr = mem_addr[ADDR_WIDTH+1:2];
  assign w_line_base = w_word_addr & LINE_MASK;
  assign w_unused    = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};

  // Dropping mem_enable kills the access in the same cycle, not one later.
  assign w_issue_rd = (r_state == S_READ)  && mem_enable;
  assign w_issue_wr = (r_state == S_WRITE) && mem_enable;
  assign w_cnt_end  = (r_cnt == r_cnt_max);

  assign busy          = (r_state != S_IDLE);
  assign ram_en        = w_issue_rd || w_issue_wr;
  assign ram_we        = w_issue_wr;
  assign ram_addr      = ram_en ? (r_base + ADDR_WIDTH'(r_cnt)) : '0;
  assign ram_wdata     = w_issue_wr ? mem_write : '0;
  assign mem_write_req = w_issue_wr;

  // The RAM output register already carries the word; the strobes are delayed flags.
  assign mem_read_valid = r_valid && mem_enable;
  assign mem_read       = mem_read_valid ? ram_rdata : '0;
  assign mem_last       = (r_rlast && mem_enable) || (w_issue_wr && w_cnt_end);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_cnt_max <= '0;
      r_base    <= '0;
      r_valid   <= 1'b0;
      r_rlast   <= 1'b0;
    end else begin
      r_valid <= w_issue_rd;
      r_rlast <= w_issue_rd && w_cnt_end;
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (mem_enable) begin
            r_base    <= mem_op_size ? w_word_addr : w_line_base;
            r_cnt_max <= mem_op_size ? '0 : LAST_BURST;
            r_state   <= (mem_rw == MEM_WRITE) ? S_WRITE : S_READ;
          end
        end
        S_READ: begin
          if (!mem_enable) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (w_cnt_end) begin
            r_state <= S_DRAIN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DRAIN: begin
          r_state <= mem_enable ? S_GAP : S_IDLE;
        end
        S_WRITE: begin
          if (!mem_enable) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (w_cnt_end) begin
            r_state <= S_GAP;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_GAP: begin
          // One dead cycle so a request still held from the last transaction is not re-taken.
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_sequencer.sv
// Directed bench for ram_burst_sequencer: behavioural RAM, golden memory image and
// a read scoreboard queue filled at issue time and drained on mem_read_valid.
module tb_ram_burst_sequencer;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic        mem_enable;
  logic        mem_rw;
  logic        mem_op_size;
  logic [31:0] mem_write;
  logic        mem_write_req;
  logic [31:0] mem_read;
  logic        mem_read_valid;
  logic        mem_last;
  logic        busy;
  logic        ram_en;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;

  logic [31:0] ram_mem [0:65535];
  logic [31:0] golden  [0:65535];
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [31:0] pl_data = '0;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } sb_item_t;
  sb_item_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_burst_sequencer #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(16),
    .BURST_LEN (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_addr      (mem_addr),
    .mem_enable    (mem_enable),
    .mem_rw        (mem_rw),
    .mem_op_size   (mem_op_size),
    .mem_write     (mem_write),
    .mem_write_req (mem_write_req),
    .mem_read      (mem_read),
    .mem_read_valid(mem_read_valid),
    .mem_last      (mem_last),
    .busy          (busy),
    .ram_en        (ram_en),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_rdata     (ram_rdata)
  );

  // Single-port RAM, registered read; bench preload port used only while the DUT is idle.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end else if (pl_en) begin
      ram_mem[pl_addr] <= pl_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int addr, input logic [31:0] data);
    pl_en   = 1'b1;
    pl_addr = 16'(addr);
    pl_data = data;
    golden[addr] = data;
    next_cycle();
    pl_en = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobes"}, 32'({busy, ram_en, ram_we, mem_write_req, mem_read_valid, mem_last}), 0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 0);
    check({tag, "_ram_wdata"}, ram_wdata, 0);
    check({tag, "_mem_read"}, mem_read, 0);
  endtask

  task automatic sb_pop(input string tag);
    sb_item_t it;
    check({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      it = exp_q.pop_front();
      check({tag, "_data"}, mem_read, it.data);
      check({tag, "_last"}, 32'(mem_last), 32'(it.last));
    end
  endtask

  // Called at the start of the cycle in which the request is presented.
  task automatic do_read(input logic [31:0] addr, input logic size, input int n,
                         input logic [15:0] base, input bit from_gap, input bit keep_en);
    sb_item_t    it;
    logic [15:0] a;
    mem_addr = addr; mem_rw = MEM_READ; mem_op_size = size; mem_enable = 1'b1;
    if (from_gap) begin
      @(negedge clk);
      check("gap_busy", 32'(busy), 1);
      check("gap_ram_en", 32'(ram_en), 0);
      next_cycle();
    end
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    next_cycle();
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clk);
      check("rd_ram_en", 32'(ram_en), 32'(k <= n));
      if (k <= n) begin
        a = base + 16'(k - 1);
        check("rd_ram_addr", 32'(ram_addr), 32'(a));
        check("rd_ram_we", 32'(ram_we), 0);
        it.data = golden[a];
        it.last = (k == n);
        exp_q.push_back(it);
      end
      check("rd_valid", 32'(mem_read_valid), 32'(k >= 2));
      if (mem_read_valid) sb_pop("rd");
      else check("rd_last_idle", 32'(mem_last), 0);
      check("rd_busy", 32'(busy), 1);
      next_cycle();
    end
    if (!keep_en) begin
      mem_enable = 1'b0;
      @(negedge clk);
      check("rd_gap_busy", 32'(busy), 1);
      check("rd_gap_strobes", 32'({ram_en, mem_read_valid, mem_last}), 0);
      next_cycle();
      @(negedge clk);
      check("rd_end_busy", 32'(busy), 0);
      next_cycle();
    end
    check("rd_sb_drained", 32'(exp_q.size()), 0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic size, input int n,
                          input logic [15:0] base, input logic [31:0] data_base);
    int          pulses;
    logic [15:0] a;
    pulses = 0;
    mem_addr = addr; mem_rw = MEM_WRITE; mem_op_size = size; mem_enable = 1'b1;
    @(negedge clk);
    check("wr_idle_busy", 32'(busy), 0);
    next_cycle();
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (mem_write_req) begin
        mem_write = data_base + 32'(pulses);
        golden[base + 16'(pulses)] = mem_write;
        pulses++;
      end
      #1;
      a = base + 16'(k - 1);
      check("wr_req", 32'(mem_write_req), 1);
      check("wr_ram_en_we", 32'({ram_en, ram_we}), 32'b11);
      check("wr_ram_addr", 32'(ram_addr), 32'(a));
      check("wr_ram_wdata", ram_wdata, data_base + 32'(k - 1));
      check("wr_last", 32'(mem_last), 32'(k == n));
      next_cycle();
    end
    mem_enable = 1'b0;
    @(negedge clk);
    if (mem_write_req) pulses++;
    check("wr_gap_strobes", 32'({mem_write_req, ram_en, mem_last}), 0);
    check("wr_gap_busy", 32'(busy), 1);
    check("wr_pulses", 32'(pulses), 32'(n));
    next_cycle();
    @(negedge clk);
    check("wr_end_busy", 32'(busy), 0);
    next_cycle();
  endtask

  initial begin
    sb_item_t it;
    rst_n = 1'b0; mem_addr = '0; mem_enable = 1'b0; mem_rw = MEM_READ;
    mem_op_size = 1'b0; mem_write = '0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_all_zero("reset");
    next_cycle();

    for (int i = 0; i < 8; i++) preload(32'h20 + i, 32'hA0 + 32'(i));
    for (int i = 0; i < 8; i++) preload(32'h80 + i, 32'hB0 + 32'(i));
    for (int i = 0; i < 8; i++) preload(32'h60 + i, 32'hDEAD_0000 + 32'(i));
    preload(1, 32'h5A5A_0001);
    rst_n = 1'b1;
    next_cycle();

    // Burst read, mid-line address
    do_read(32'h0000_008C, 1'b0, 8, 16'h20, 1'b0, 1'b0);

    // Burst write, requester supplies 0x1000+k
    do_write(32'h0000_0104, 1'b0, 8, 16'h40, 32'h1000);
    for (int i = 0; i < 8; i++) check("wr_ram_content", ram_mem[32'h40 + i], 32'h1000 + 32'(i));

    // Single word
    do_read(32'h0000_0006, 1'b1, 1, 16'h1, 1'b0, 1'b0);

    // Back-to-back: enable held through GAP with a new request
    do_read(32'h0000_008C, 1'b0, 8, 16'h20, 1'b0, 1'b1);
    do_read(32'h0000_0104, 1'b0, 8, 16'h40, 1'b1, 1'b0);

    // Abort: enable drops at t0+3
    mem_addr = 32'h0000_0200; mem_rw = MEM_READ; mem_op_size = 1'b0; mem_enable = 1'b1;
    @(negedge clk);
    next_cycle();
    for (int k = 1; k <= 6; k++) begin
      if (k == 3) mem_enable = 1'b0;
      @(negedge clk);
      check("ab_ram_en", 32'(ram_en), 32'(k < 3));
      if (k < 3) begin
        it.data = golden[32'h80 + k - 1];
        it.last = 1'b0;
        exp_q.push_back(it);
      end
      if (k == 2) check("ab_valid_k2", 32'(mem_read_valid), 1);
      if (k <= 3 && mem_read_valid) sb_pop("ab");
      if (k >= 4) begin
        check("ab_valid_after", 32'(mem_read_valid), 0);
        check("ab_busy_after", 32'(busy), 0);
      end
      check("ab_no_last", 32'(mem_last), 0);
      next_cycle();
    end
    exp_q.delete();
    do_read(32'h0000_0200, 1'b0, 8, 16'h80, 1'b0, 1'b0);

    // Reset at t0+4 of a burst write
    mem_addr = 32'h0000_0180; mem_rw = MEM_WRITE; mem_op_size = 1'b0; mem_enable = 1'b1;
    @(negedge clk);
    next_cycle();
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) rst_n = 1'b0;
      @(negedge clk);
      if (mem_write_req) mem_write = 32'h2000 + 32'(k - 1);
      next_cycle();
    end
    mem_enable = 1'b0;
    @(negedge clk);
    check_all_zero("mid_rst");
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_rst");
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      check("rst_wr_done", ram_mem[32'h60 + i], 32'h2000 + 32'(i));
      golden[32'h60 + i] = 32'h2000 + 32'(i);
    end
    for (int i = 4; i < 8; i++) check("rst_wr_untouched", ram_mem[32'h60 + i], 32'hDEAD_0000 + 32'(i));
    do_read(32'h0000_0180, 1'b0, 8, 16'h60, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_burst_sequencer.md
# ram_burst_sequencer

Sequences the single-port synchronous block RAM on behalf of the memory arbiter. It converts one granted request (cache-line burst or single word, read or write) into per-word RAM accesses. It generates the per-word read-valid, write-request and last-word strobes that the arbiter forwards to the instruction cache, the data cache and the external-storage port. It sits between the arbiter's `mem_*` bus and the RAM macro.

## Interface
- DATA_WIDTH, 32, RAM word width
- ADDR_WIDTH, 16, RAM word-address width
- BURST_LEN, 8, words per cache-line burst; power of two, 2..64
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- mem_addr  in  32  byte address of request
- mem_enable  in  1  request active; held by arbiter for whole transaction
- mem_rw  in  1  `MEM_READ` / `MEM_WRITE`
- mem_op_size  in  1  0 = burst of BURST_LEN words, 1 = single word
- mem_write  in  DATA_WIDTH  write word; valid in the cycle mem_write_req=1
- mem_write_req  out  1  requester must present next write word this cycle
- mem_read  out  DATA_WIDTH  read word
- mem_read_valid  out  1  mem_read holds a valid word
- mem_last  out  1  final word of transaction (with valid or write_req)
- busy  out  1  high in every state except IDLE
- ram_en  out  1  RAM access enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_WIDTH  RAM word address
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_rdata  in  DATA_WIDTH  RAM read data, 1-cycle latency after ram_en

## Operation
- Word address = mem_addr[ADDR_WIDTH+1:2]. mem_addr[1:0] and bits above ADDR_WIDTH+1 are ignored.
- Burst: base = word address with the low log2(BURST_LEN) bits cleared. Words are issued base+0 .. base+BURST_LEN-1 in ascending order.
- Single word: base = word address; word count N = 1.
- Base, N and direction are latched at acceptance. Changes to mem_addr, mem_rw or mem_op_size during a transaction are ignored.
- States:
  - IDLE: accept when mem_enable=1. Go to READ or WRITE per mem_rw.
  - READ: issue ram_en=1, ram_we=0, ram_addr=base+cnt each cycle, cnt 0..N-1. After the last issue, go to DRAIN.
  - DRAIN: one cycle capturing the final read word. Then go to GAP.
  - WRITE: mem_write_req=1 combinationally each cycle. Drive ram_en=1, ram_we=1, ram_addr=base+cnt, ram_wdata=mem_write. After cnt=N-1, go to GAP.
  - GAP: one cycle; mem_enable ignored. Then go to IDLE. This guarantees the arbiter's one-cycle READY slot and avoids re-accepting a stale request.
- Read data path:
  - mem_read and mem_read_valid are registered from ram_rdata one cycle after each issue.
  - mem_last is registered, high together with the Nth valid word only.
- Counter cnt is log2(BURST_LEN)+1 bits. Address addition is truncated to ADDR_WIDTH, so a line at the top of RAM never crosses it because bases are aligned.
- Abort: mem_enable=0 in READ, DRAIN or WRITE causes:
  - the next edge to enter IDLE directly;
  - no ram_en from that cycle on (it is gated combinationally);
  - in-flight read data to be discarded, with mem_read_valid and mem_last held 0;
  - no mem_last for the aborted transaction.

## Timing
- Reset (rst_n=0 at an edge), from the next cycle:
  - state=IDLE, cnt=0;
  - mem_read=0, mem_read_valid=0, mem_last=0, mem_write_req=0, busy=0;
  - ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
- Reset mid-burst aborts with no further strobes.
- Acceptance edge = t0.
- Read:
  - ram_en in cycles t0+1 .. t0+N.
  - mem_read_valid in cycles t0+2 .. t0+N+1.
  - mem_last in cycle t0+N+1.
  - GAP at t0+N+2; IDLE at t0+N+3.
  - Earliest next acceptance is at the end of cycle t0+N+3.
- Write:
  - mem_write_req and RAM writes in cycles t0+1 .. t0+N.
  - mem_last in cycle t0+N.
  - GAP at t0+N+1.
- Throughput: one word per cycle, no bubbles inside a burst.
- Burst read latency is N+1 cycles; burst write latency is N cycles.
- In IDLE and GAP, ram_en=0, mem_write_req=0 and mem_read_valid=0.

## Test plan
- Burst read: preload RAM words 0x20..0x27 with 0xA0+i, then request read at byte address 0x0000_008C, op_size=0. Required response: ram_addr 0x20..0x27; mem_read 0xA0..0xA7 in cycles t0+2..t0+9; mem_last only at t0+9; busy low at t0+11.
- Burst write: request write at byte address 0x104; requester returns 0x1000+k on each mem_write_req. Required response: RAM 0x40..0x47 holds 0x1000..0x1007; exactly 8 write_req pulses; mem_last with the 8th.
- Single word: read at byte address 0x0000_0006, op_size=1. Required response: one ram_en at word 1; one valid with mem_last asserted at t0+2.
- Back-to-back: arbiter re-asserts mem_enable in the cycle right after mem_last. Required response: request ignored during GAP; accepted one cycle later; no duplicate or skipped words.
- Abort: drop mem_enable at t0+3 of a burst read. Required response: ram_en low from t0+3; no mem_read_valid after t0+3; no mem_last; busy=0 at t0+4; a fresh read then completes correctly.
- Reset mid-write: rst_n=0 at t0+4 of a burst write. Required response: all outputs 0 from the next cycle; RAM words beyond index 3 unchanged; a normal transaction succeeds after release.
